// File: rtl/ad7656_bus_wr_ctrl.sv
// Buffered parallel-bus write controller for AD7656-class control registers.
// Optional sticky overflow status: define AD7656_WR_OVF_STATUS_EN.
`timescale 1ns/1ps

module ad7656_bus_wr_ctrl #(
  parameter int              WORD_W     = 8,
  parameter int              BUS_W      = 16,
  parameter logic [BUS_W-1:0] PAD_VALUE = {BUS_W{1'b1}},
  parameter bit              DATA_HIGH  = 1'b1,
  parameter int              T_SETUP    = 1,
  parameter int              T_WR       = 2,
  parameter int              T_HOLD     = 1,
  parameter int              T_GAP      = 1,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic                          sys_clk_i,
  input  logic                          rst_n_i,
  input  logic                          wr_valid_i,
  input  logic [WORD_W-1:0]             wr_data_i,
  output logic                          wr_ready_o,
  output logic                          bus_busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          done_o,
  output logic                          cs_n_o,
  output logic                          wr_n_o,
  output logic [BUS_W-1:0]              DB_o
`ifdef AD7656_WR_OVF_STATUS_EN
  ,
  input  logic                          ovf_clr_i,
  output logic                          ovf_o
`endif
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int T_M1  = (T_SETUP > T_WR) ? T_SETUP : T_WR;
  localparam int T_M2  = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
  localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_GAP
  } state_t;

  // Handshake: a word transfers on any clock edge where wr_valid_i and
  // wr_ready_o are both high; the source must hold the word until then.

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  state_t            state_q;
  state_t            next_state;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] data_q;
  logic              cs_n_q;
  logic              wr_n_q;
  logic              done_q;
  logic [BUS_W-1:0]  db;

  assign full  = (level_q == LW'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  // Readiness depends only on the current level, so a pop cannot free a slot
  // for a push in the same cycle.
  assign push  = wr_valid_i && !full;

  always_ff @(posedge sys_clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_comb begin
    next_state = state_q;
    pop        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = S_SETUP;
        end
      end
      S_SETUP:  if (cnt_q == CNT_W'(T_SETUP - 1)) next_state = S_STROBE;
      S_STROBE: if (cnt_q == CNT_W'(T_WR - 1))    next_state = S_HOLD;
      S_HOLD:   if (cnt_q == CNT_W'(T_HOLD - 1))  next_state = S_GAP;
      S_GAP: begin
        if (cnt_q == CNT_W'(T_GAP - 1)) begin
          if (!empty) begin
            pop        = 1'b1;
            next_state = S_SETUP;
          end else begin
            next_state = S_IDLE;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Strobes are decoded from next_state so each register tracks the state
  // register on the same edge, without an extra cycle of lag.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= next_state;
      cnt_q   <= ((next_state != state_q) || (next_state == S_IDLE)) ? '0 : cnt_q + 1'b1;
      if (pop) begin
        data_q <= mem_q[rd_ptr_q];
      end
      cs_n_q  <= !((next_state == S_SETUP) || (next_state == S_STROBE) || (next_state == S_HOLD));
      wr_n_q  <= (next_state != S_STROBE);
      done_q  <= (next_state == S_GAP) && (state_q != S_GAP);
    end
  end

  always_comb begin
    db = PAD_VALUE;
    if (DATA_HIGH) begin
      db[BUS_W-1 -: WORD_W] = data_q;
    end else begin
      db[WORD_W-1:0] = data_q;
    end
  end

  assign wr_ready_o   = !full;
  assign bus_busy_o   = !empty || (state_q != S_IDLE);
  assign fifo_level_o = level_q;
  assign done_o       = done_q;
  assign cs_n_o       = cs_n_q;
  assign wr_n_o       = wr_n_q;
  assign DB_o         = db;

`ifdef AD7656_WR_OVF_STATUS_EN
  logic ovf_q;

  // A refused request in the same cycle as a clear keeps the flag set.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf_q <= 1'b0;
    end else if (wr_valid_i && full) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr_i) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_ad7656_bus_wr_ctrl.sv
// Bench for ad7656_bus_wr_ctrl: vector tables plus a bus scoreboard on the
// default instance, and a second instance with slow timing and low payload.
`timescale 1ns/1ps

module tb_ad7656_bus_wr_ctrl;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // default instance
  logic        wv = 1'b0;
  logic [7:0]  wd = '0;
  logic        rdy, busy, done, cs_n, wr_n;
  logic [2:0]  lvl;
  logic [15:0] db;

  // slow instance: DATA_HIGH=0, 2/3/2/3 timing
  logic        wv2 = 1'b0;
  logic [7:0]  wd2 = '0;
  logic        rdy2, busy2, done2, cs2, wr2;
  logic [2:0]  lvl2;
  logic [15:0] db2;

`ifdef AD7656_WR_OVF_STATUS_EN
  logic ovf_clr = 1'b0;
  logic ovf;
  logic ovf_clr2 = 1'b0;
  logic ovf2;
`endif

  ad7656_bus_wr_ctrl dut (
    .sys_clk_i(clk), .rst_n_i(rst_n), .wr_valid_i(wv), .wr_data_i(wd),
    .wr_ready_o(rdy), .bus_busy_o(busy), .fifo_level_o(lvl), .done_o(done),
    .cs_n_o(cs_n), .wr_n_o(wr_n), .DB_o(db)
`ifdef AD7656_WR_OVF_STATUS_EN
    , .ovf_clr_i(ovf_clr), .ovf_o(ovf)
`endif
  );

  ad7656_bus_wr_ctrl #(
    .DATA_HIGH(1'b0), .T_SETUP(2), .T_WR(3), .T_HOLD(2), .T_GAP(3)
  ) dut_slow (
    .sys_clk_i(clk), .rst_n_i(rst_n), .wr_valid_i(wv2), .wr_data_i(wd2),
    .wr_ready_o(rdy2), .bus_busy_o(busy2), .fifo_level_o(lvl2), .done_o(done2),
    .cs_n_o(cs2), .wr_n_o(wr2), .DB_o(db2)
`ifdef AD7656_WR_OVF_STATUS_EN
    , .ovf_clr_i(ovf_clr2), .ovf_o(ovf2)
`endif
  );

  // scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp2_q[$];
  int fall_q[$];
  int done_cnt = 0;
  int viol = 0;
  int cs_run = 0;
  int wr_run = 0;
  logic prev_cs = 1'b1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic        v;
    logic [7:0]  d;
    logic        clr;
    logic        cs_n;
    logic        wr_n;
    logic        done;
    logic        busy;
    logic        ready;
    logic [2:0]  level;
    logic [15:0] db;
    logic        ovf;
  } vec_t;

  vec_t tbl [0:15];

  function automatic vec_t mk(logic v_, logic [7:0] d_, logic clr_, logic cs_, logic wr_,
                              logic dn_, logic bz_, logic rd_, logic [2:0] lv_,
                              logic [15:0] db_, logic ov_);
    mk = {v_, d_, clr_, cs_, wr_, dn_, bz_, rd_, lv_, db_, ov_};
  endfunction

  // bus monitor for the default instance: pushes on accepted words,
  // compares DB_o while cs_n is low and at each done pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      cs_run  = 0;
      wr_run  = 0;
      prev_cs = 1'b1;
    end else begin
      if (wv && rdy) exp_q.push_back({wd, 8'hFF});
      if (!cs_n && exp_q.size() > 0) check("bus.db_stable", db, exp_q[0]);
      if (done) begin
        done_cnt++;
        check("bus.done_has_exp", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("bus.db_at_done", db, exp_q.pop_front());
      end
      if (!cs_n && prev_cs) fall_q.push_back(cyc);
      if (!wr_n && cs_n) viol++;
      if (!cs_n) cs_run++;
      else if (cs_run != 0) begin
        check("bus.cs_low_len", cs_run, 4);
        cs_run = 0;
      end
      if (!wr_n) wr_run++;
      else if (wr_run != 0) begin
        check("bus.wr_low_len", wr_run, 2);
        wr_run = 0;
      end
      prev_cs = cs_n;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wv = 1'b0; wv2 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic run_table(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      wv = tbl[i].v;
      wd = tbl[i].d;
`ifdef AD7656_WR_OVF_STATUS_EN
      ovf_clr = tbl[i].clr;
`endif
      @(negedge clk);
      check($sformatf("%s[%0d].cs_n", name, i), cs_n, tbl[i].cs_n);
      check($sformatf("%s[%0d].wr_n", name, i), wr_n, tbl[i].wr_n);
      check($sformatf("%s[%0d].done", name, i), done, tbl[i].done);
      check($sformatf("%s[%0d].busy", name, i), busy, tbl[i].busy);
      check($sformatf("%s[%0d].ready", name, i), rdy, tbl[i].ready);
      check($sformatf("%s[%0d].level", name, i), lvl, tbl[i].level);
      check($sformatf("%s[%0d].db", name, i), db, tbl[i].db);
`ifdef AD7656_WR_OVF_STATUS_EN
      check($sformatf("%s[%0d].ovf", name, i), ovf, tbl[i].ovf);
`endif
      step();
    end
    wv = 1'b0;
`ifdef AD7656_WR_OVF_STATUS_EN
    ovf_clr = 1'b0;
`endif
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      step();
      n++;
    end
    check({name, ".drain_queue"}, exp_q.size(), 0);
    check({name, ".drain_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs_falls[$];
    int wr_falls[$];
    int cs_low1, wr_low1, base, cs_seen, busy_seen;
    logic p_cs2, p_wr2;

    // reset state
    do_reset();
    @(negedge clk);
    check("reset.cs_n", cs_n, 1);
    check("reset.wr_n", wr_n, 1);
    check("reset.done", done, 0);
    check("reset.ready", rdy, 1);
    check("reset.busy", busy, 0);
    check("reset.level", lvl, 0);
    check("reset.db", db, 16'h00FF);
    check("reset.db_slow", db2, 16'hFF00);
`ifdef AD7656_WR_OVF_STATUS_EN
    check("reset.ovf", ovf, 0);
`endif

    // single write of A5
    do_reset();
    tbl[0] = mk(1, 8'hA5, 0, 1, 1, 0, 0, 1, 3'd0, 16'h00FF, 0);
    tbl[1] = mk(0, 8'h00, 0, 1, 1, 0, 1, 1, 3'd1, 16'h00FF, 0);
    tbl[2] = mk(0, 8'h00, 0, 0, 1, 0, 1, 1, 3'd0, 16'hA5FF, 0);
    tbl[3] = mk(0, 8'h00, 0, 0, 0, 0, 1, 1, 3'd0, 16'hA5FF, 0);
    tbl[4] = mk(0, 8'h00, 0, 0, 0, 0, 1, 1, 3'd0, 16'hA5FF, 0);
    tbl[5] = mk(0, 8'h00, 0, 0, 1, 0, 1, 1, 3'd0, 16'hA5FF, 0);
    tbl[6] = mk(0, 8'h00, 0, 1, 1, 1, 1, 1, 3'd0, 16'hA5FF, 0);
    tbl[7] = mk(0, 8'h00, 0, 1, 1, 0, 0, 1, 3'd0, 16'hA5FF, 0);
    tbl[8] = mk(0, 8'h00, 0, 1, 1, 0, 0, 1, 3'd0, 16'hA5FF, 0);
    run_table("single", 9);
    drain("single");

    // burst of four words
    do_reset();
    fall_q.delete();
    base = done_cnt;
    for (int i = 0; i < 5; i++) begin
      wv = (i < 4);
      wd = 8'(i + 1);
      @(negedge clk);
      check($sformatf("burst.ready[%0d]", i), rdy, 1);
      step();
    end
    wv = 1'b0;
    drain("burst");
    check("burst.windows", fall_q.size(), 4);
    if (fall_q.size() == 4) begin
      for (int k = 1; k < 4; k++) check($sformatf("burst.period[%0d]", k), fall_q[k] - fall_q[k-1], 5);
    end
    check("burst.dones", done_cnt - base, 4);

    // FIFO full with a held request, overflow flag set/clear
    do_reset();
    tbl[0] = mk(1, 8'hA0, 0, 1, 1, 0, 0, 1, 3'd0, 16'h00FF, 0);
    tbl[1] = mk(1, 8'hB1, 0, 1, 1, 0, 1, 1, 3'd1, 16'h00FF, 0);
    tbl[2] = mk(1, 8'hB2, 0, 0, 1, 0, 1, 1, 3'd1, 16'hA0FF, 0);
    tbl[3] = mk(1, 8'hB3, 0, 0, 0, 0, 1, 1, 3'd2, 16'hA0FF, 0);
    tbl[4] = mk(1, 8'hB4, 0, 0, 0, 0, 1, 1, 3'd3, 16'hA0FF, 0);
    tbl[5] = mk(1, 8'h77, 0, 0, 1, 0, 1, 0, 3'd4, 16'hA0FF, 0);
    tbl[6] = mk(1, 8'h77, 1, 1, 1, 1, 1, 0, 3'd4, 16'hA0FF, 1);
    tbl[7] = mk(1, 8'h77, 0, 0, 1, 0, 1, 1, 3'd3, 16'hB1FF, 1);
    tbl[8] = mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 3'd4, 16'hB1FF, 1);
    tbl[9] = mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 3'd4, 16'hB1FF, 0);
    run_table("full", 10);
    drain("full");

    // slow instance, low payload, two words
    do_reset();
    cs_low1 = 0; wr_low1 = 0;
    p_cs2 = 1'b1; p_wr2 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      wv2 = (i < 2);
      wd2 = (i == 0) ? 8'h3C : 8'h5A;
      @(negedge clk);
      if (wv2 && rdy2) exp2_q.push_back({8'hFF, wd2});
      if (!cs2 && p_cs2) cs_falls.push_back(i);
      if (!wr2 && p_wr2) wr_falls.push_back(i);
      if (!cs2 && cs_falls.size() == 1) cs_low1++;
      if (!wr2 && wr_falls.size() == 1) wr_low1++;
      if (!cs2 && exp2_q.size() > 0) check("slow.db_stable", db2, exp2_q[0]);
      if (done2) begin
        check("slow.done_has_exp", exp2_q.size() != 0, 1);
        if (exp2_q.size() != 0) check("slow.db_at_done", db2, exp2_q.pop_front());
      end
      p_cs2 = cs2;
      p_wr2 = wr2;
      step();
    end
    wv2 = 1'b0;
    check("slow.windows", cs_falls.size(), 2);
    check("slow.wr_windows", wr_falls.size(), 2);
    if (cs_falls.size() == 2 && wr_falls.size() == 2) begin
      check("slow.cs_first", cs_falls[0], 2);
      check("slow.period", cs_falls[1] - cs_falls[0], 10);
      check("slow.wr_offset", wr_falls[0] - cs_falls[0], 2);
    end
    check("slow.cs_low_len", cs_low1, 7);
    check("slow.wr_low_len", wr_low1, 3);
    check("slow.queue_empty", exp2_q.size(), 0);
    check("slow.idle", busy2, 0);
`ifdef AD7656_WR_OVF_STATUS_EN
    check("slow.ovf", ovf2, 0);
`endif

    // reset asserted during STROBE with two words still queued
    do_reset();
    wv = 1'b1; wd = 8'hC1;
    step();
    wd = 8'hC2;
    step();
    wd = 8'hC3;
    step();
    wv = 1'b0;
    @(negedge clk);
    check("rst.in_strobe", wr_n, 0);
    check("rst.queued", lvl, 2);
    #2 rst_n = 1'b0;
    #1;
    check("rst.cs_n", cs_n, 1);
    check("rst.wr_n", wr_n, 1);
    check("rst.level", lvl, 0);
    check("rst.busy", busy, 0);
    check("rst.ready", rdy, 1);
    check("rst.done", done, 0);
    check("rst.db", db, 16'h00FF);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cs_seen = 0; busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cs_n) cs_seen++;
      if (busy) busy_seen++;
    end
    check("rst.no_bus_activity", cs_seen, 0);
    check("rst.stays_idle", busy_seen, 0);
    check("rst.level_after", lvl, 0);

    check("bus.wr_outside_cs", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ad7656_bus_wr_ctrl.md
Name: ad7656_bus_wr_ctrl

Overview:
Parametrised parallel-bus write controller for AD7656-class converter control/config registers.
Accepts payload words over a valid/ready handshake into a small FIFO, then drains them one by one onto DB_o with programmable CS/WR setup, strobe, hold and gap timing.
Sits between the register/command logic and the ADC pin interface; next generation of the fixed 4-cycle write driver, with configurable timing, width, payload position and buffering.

Parameters:
WORD_W, 8, payload width in bits.
BUS_W, 16, DB_o width; must be ≥ WORD_W.
PAD_VALUE, all ones ({BUS_W{1'b1}}), fill value for DB_o bits not carrying payload.
DATA_HIGH, 1, 1 = payload in DB_o[BUS_W-1 -: WORD_W]; 0 = payload in DB_o[WORD_W-1:0].
T_SETUP, 1, cycles with cs_n low before wr_n falls (≥1).
T_WR, 2, cycles with wr_n low (≥1).
T_HOLD, 1, cycles with cs_n low after wr_n rises (≥1).
T_GAP, 1, minimum cycles with cs_n high between writes (≥1).
FIFO_DEPTH, 4, command FIFO depth; power of 2, ≥2.

Ports:
sys_clk_i  in  1  system clock, 100 MHz
rst_n_i  in  1  reset; asynchronous assert, active-low
wr_valid_i  in  1  write request valid
wr_data_i  in  WORD_W  payload word
wr_ready_o  out  1  FIFO can accept a word
bus_busy_o  out  1  FIFO non-empty or FSM not IDLE
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  words held in FIFO
done_o  out  1  one-cycle pulse per completed bus write
cs_n_o  out  1  chip select, active-low
wr_n_o  out  1  write strobe, active-low
DB_o  out  BUS_W  data bus

Behaviour:
- One clock: sys_clk_i. Reset: rst_n_i, asynchronous, active-low.
- Reset values and action: cs_n_o=1, wr_n_o=1, done_o=0, wr_ready_o=1, bus_busy_o=0, fifo_level_o=0, data register=0, DB_o = payload 0 merged with PAD_VALUE (default 16'h00FF).
- Reset mid-transfer: outputs return to the reset values immediately; FIFO is flushed; FSM goes to IDLE.
- Handshake and FIFO:
  - Push when wr_valid_i & wr_ready_o.
  - wr_ready_o = !full; a push is refused when full, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle: level unchanged.
  - A word pushed in cycle n is visible to the FSM in cycle n+1.
- FSM states: IDLE, SETUP, STROBE, HOLD, GAP. A per-phase counter is cleared on every state change.
  - IDLE: if FIFO non-empty, pop into the data register and go to SETUP.
  - SETUP: after T_SETUP cycles, go to STROBE.
  - STROBE: after T_WR cycles, go to HOLD.
  - HOLD: after T_HOLD cycles, go to GAP.
  - GAP: after T_GAP cycles, if FIFO non-empty pop and go directly to SETUP, else go to IDLE.
- Output decode:
  - cs_n_o, wr_n_o and done_o are registered, decoded from next_state, so each tracks the state with zero additional lag and is glitch-free.
  - cs_n_o = 0 in SETUP, STROBE and HOLD; wr_n_o = 0 in STROBE only.
  - wr_n_o is never low while cs_n_o is high.
- done_o pulses in the first GAP cycle.
- Timing: cs_n low = T_SETUP+T_WR+T_HOLD cycles; back-to-back period = T_SETUP+T_WR+T_HOLD+T_GAP cycles (defaults: 4 and 5).
- Latency (idle): push at cycle n → pop at n+1 → cs_n_o low from n+2.
- Data bus:
  - DB_o is driven from the data register, which loads only on pop, and is stable throughout SETUP..HOLD.
  - DB_o holds its last value between writes.
  - Unused bits carry PAD_VALUE.

Optional Feature:
Macro AD7656_WR_OVF_STATUS_EN.
- Defined: adds input ovf_clr_i (1 bit) and output ovf_o (1 bit, reset 0).
  - ovf_o sets sticky when wr_valid_i=1 while wr_ready_o=0.
  - ovf_clr_i clears it; if set and clear coincide, set wins.
- Not defined: neither port exists; a refused request is silently held by the source per the handshake.

Test Plan:
- Single write, defaults, wr_data_i=8'hA5 pushed at cycle 0 → cs_n_o low cycles 2–5; wr_n_o low cycles 3–4; DB_o=16'hA5FF from cycle 2; done_o pulse cycle 6; bus_busy_o falls at cycle 7.
- Burst of 4 words 8'h01..8'h04 pushed back-to-back → wr_ready_o deasserts after the 4th push only if no pop has occurred yet; four cs_n_o windows with period 5; DB_o sequence 01FF, 02FF, 03FF, 04FF; four done_o pulses.
- DATA_HIGH=0, T_SETUP=2, T_WR=3, T_HOLD=2, T_GAP=3, write 8'h3C → DB_o=16'hFF3C; cs_n_o low 7 cycles; wr_n_o low 3 cycles beginning 2 cycles after cs_n_o falls; period 10 for a second word.
- FIFO full, then wr_valid_i held high with 8'h77 → not accepted until a pop occurs; fifo_level_o never exceeds 4; with the macro defined, ovf_o=1 until ovf_clr_i is pulsed.
- rst_n_i asserted during STROBE with 2 words queued → cs_n_o=1 and wr_n_o=1 asynchronously; fifo_level_o=0; after release no bus activity occurs without a new push.
